// File: rtl/pc_unit.sv
// Program-counter unit for the RV32 front end. Holds the fetch address,
// advances it under the fetch handshake and handles stall, redirect,
// trap entry, MRET return, misaligned-target traps and the double-fault lock.
module pc_unit #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = '0,
  parameter logic [XLEN-1:0]   TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int                INC       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause_in,
  input  logic            mret,
  output logic [XLEN-1:0] addr,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] tval,
  output logic [3:0]      cause,
  output logic            in_handler,
  output logic            locked
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_HANDLER = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [3:0]      r_cause;
  logic            r_fetch_valid;
  logic            r_in_handler;
  logic            r_locked;

  logic [XLEN-1:0] w_addr_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic [XLEN-1:0] w_tval_nxt;
  logic [3:0]      w_cause_nxt;
  logic            w_fetch_valid_nxt;
  logic            w_in_handler_nxt;
  logic            w_locked_nxt;

  logic            w_mis;
  logic            w_trap_any;
  logic            w_active;

  // A redirect to a non-word-aligned target is treated as a trap source;
  // an explicit trap request always wins over it for cause/tval.
  assign w_mis      = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign w_trap_any = trap_req || w_mis;
  assign w_active   = (r_state == S_RUN) || (r_state == S_HANDLER);

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_fetch_valid <= 1'b0;
      r_in_handler  <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_in_handler  <= w_in_handler_nxt;
      r_locked      <= w_locked_nxt;
    end
  end

  // Next-state logic: trap beats mret; mret only leaves HANDLER.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT:    w_state_nxt = S_RUN;
      S_RUN:     if (w_trap_any) w_state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (w_trap_any)  w_state_nxt = S_LOCKED;
        else if (mret)   w_state_nxt = S_RUN;
      end
      S_LOCKED:  w_state_nxt = S_LOCKED;
      default:   w_state_nxt = S_BOOT;
    endcase
  end

  // Output decode of the next state, so the status flags are registered
  // and line up with the state they describe.
  always_comb begin
    w_fetch_valid_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_HANDLER);
    w_in_handler_nxt  = (w_state_nxt == S_HANDLER);
    w_locked_nxt      = (w_state_nxt == S_LOCKED);
  end

  // PC and trap-CSR next values following the per-edge priority order.
  always_comb begin
    w_addr_nxt  = r_addr;
    w_epc_nxt   = r_epc;
    w_tval_nxt  = r_tval;
    w_cause_nxt = r_cause;
    if (w_active) begin
      if (w_trap_any) begin
        // Only the first trap records context; a nested one just locks.
        if (r_state == S_RUN) begin
          w_epc_nxt   = r_addr;
          w_cause_nxt = trap_req ? trap_cause_in : 4'd0;
          w_tval_nxt  = trap_req ? '0 : redirect_target;
          w_addr_nxt  = TRAP_VEC;
        end
      end else if (mret && (r_state == S_HANDLER)) begin
        w_addr_nxt = r_epc;
      end else if (redirect_valid) begin
        // Redirect is a flush: ignores stall and fetch_ready.
        w_addr_nxt = redirect_target;
      end else if (stall) begin
        w_addr_nxt = r_addr;
      end else if (fetch_ready) begin
        w_addr_nxt = r_addr + XLEN'(INC);
      end
    end
  end

  // PC and trap-CSR registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= RESET_VEC;
      r_epc   <= '0;
      r_tval  <= '0;
      r_cause <= 4'd0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_epc   <= w_epc_nxt;
      r_tval  <= w_tval_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  assign addr        = r_addr;
  assign fetch_valid = r_fetch_valid;
  assign epc         = r_epc;
  assign tval        = r_tval;
  assign cause       = r_cause;
  assign in_handler  = r_in_handler;
  assign locked      = r_locked;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step drives inputs, pushes the expected
// post-edge outputs to a scoreboard queue, then pops and compares them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic [3:0]  trap_cause_in;
  logic        mret;
  logic [31:0] addr;
  logic        fetch_valid;
  logic [31:0] epc;
  logic [31:0] tval;
  logic [3:0]  cause;
  logic        in_handler;
  logic        locked;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        fv;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [3:0]  cause;
    logic        ih;
    logic        lk;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .trap_cause_in   (trap_cause_in),
    .mret            (mret),
    .addr            (addr),
    .fetch_valid     (fetch_valid),
    .epc             (epc),
    .tval            (tval),
    .cause           (cause),
    .in_handler      (in_handler),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, record expectation, sample after the edge.
  task automatic step(
    input string       name,
    input logic        rst, input logic stl, input logic fr,
    input logic        rv,  input logic [31:0] rt,
    input logic        tr,  input logic [3:0] tc, input logic mr,
    input logic [31:0] e_addr, input logic e_fv,
    input logic [31:0] e_epc,  input logic [31:0] e_tval,
    input logic [3:0]  e_cause, input logic e_ih, input logic e_lk);
    exp_t e;
    exp_t got;
    reset = rst; stall = stl; fetch_ready = fr;
    redirect_valid = rv; redirect_target = rt;
    trap_req = tr; trap_cause_in = tc; mret = mr;
    e.addr = e_addr; e.fv = e_fv; e.epc = e_epc; e.tval = e_tval;
    e.cause = e_cause; e.ih = e_ih; e.lk = e_lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({name, ".addr"},  addr,                got.addr);
    chk({name, ".fv"},    {31'd0, fetch_valid}, {31'd0, got.fv});
    chk({name, ".epc"},   epc,                 got.epc);
    chk({name, ".tval"},  tval,                got.tval);
    chk({name, ".cause"}, {28'd0, cause},      {28'd0, got.cause});
    chk({name, ".ih"},    {31'd0, in_handler}, {31'd0, got.ih});
    chk({name, ".lk"},    {31'd0, locked},     {31'd0, got.lk});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; trap_req = 1'b0; trap_cause_in = 4'd0; mret = 1'b0;

    //    name     rst stl fr rv target          tr tc    mr  addr            fv epc       tval      cause ih lk
    step("rst0",   1, 0, 0, 0, 32'h0,           0, 4'h0, 0, 32'h0,          0, 32'h0,    32'h0,    4'h0, 0, 0);
    step("rst1",   1, 0, 0, 0, 32'h0,           0, 4'h0, 0, 32'h0,          0, 32'h0,    32'h0,    4'h0, 0, 0);
    // BOOT cycle ignores fetch_ready: addr stays at the reset vector.
    step("boot",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h0,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("inc1",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h4,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("inc2",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h8,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("inc3",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'hC,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("stall1", 0, 1, 1, 0, 32'h0,           0, 4'h0, 0, 32'hC,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("stall2", 0, 1, 1, 0, 32'h0,           0, 4'h0, 0, 32'hC,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("idle",   0, 0, 0, 0, 32'h0,           0, 4'h0, 0, 32'hC,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("redir",  0, 1, 0, 1, 32'h40,          0, 4'h0, 0, 32'h40,         1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("inc4",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h44,         1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("mis",    0, 0, 0, 1, 32'h42,          0, 4'h0, 0, 32'h100,        1, 32'h44,   32'h42,   4'h0, 1, 0);
    step("hinc",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h104,        1, 32'h44,   32'h42,   4'h0, 1, 0);
    // mret outranks a simultaneous aligned redirect.
    step("mret",   0, 0, 0, 1, 32'h80,          0, 4'h0, 1, 32'h44,         1, 32'h44,   32'h42,   4'h0, 0, 0);
    step("mretrun",0, 0, 1, 0, 32'h0,           0, 4'h0, 1, 32'h48,         1, 32'h44,   32'h42,   4'h0, 0, 0);
    // trap_req beats a simultaneous misaligned redirect.
    step("trap",   0, 0, 0, 1, 32'h43,          1, 4'hB, 0, 32'h100,        1, 32'h48,   32'h0,    4'hB, 1, 0);
    step("dfault", 0, 0, 1, 0, 32'h0,           1, 4'h5, 0, 32'h100,        0, 32'h48,   32'h0,    4'hB, 0, 1);
    step("lkhold", 0, 0, 1, 1, 32'h200,         0, 4'h0, 1, 32'h100,        0, 32'h48,   32'h0,    4'hB, 0, 1);
    step("lkrst",  1, 0, 1, 0, 32'h0,           1, 4'h7, 0, 32'h0,          0, 32'h0,    32'h0,    4'h0, 0, 0);
    step("boot2",  0, 0, 0, 0, 32'h0,           0, 4'h0, 0, 32'h0,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("rtop",   0, 0, 1, 1, 32'hFFFF_FFFC,   0, 4'h0, 0, 32'hFFFF_FFFC,  1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("wrap",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h0,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    step("inc5",   0, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h4,          1, 32'h0,    32'h0,    4'h0, 0, 0);
    // Misaligned by one byte while stalled still traps.
    step("mis1",   0, 1, 0, 1, 32'h61,          0, 4'h0, 0, 32'h100,        1, 32'h4,    32'h61,   4'h0, 1, 0);
    step("hrst",   1, 0, 1, 0, 32'h0,           0, 4'h0, 0, 32'h0,          0, 32'h0,    32'h0,    4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
